// File: rtl/udma_adc_ts_pkg.sv
// Package for the uDMA ADC timestamp event scheduler.
// Provides the scheduler FSM state type, default parameter values and
// width helpers shared by the top level and the arbiter.
package udma_adc_ts_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        LAUNCH = 2'd2,
        HOLD   = 2'd3
    } sched_state_e;

    localparam int unsigned TS_NUM_CHS_DEF    = 32'd8;
    localparam int unsigned TS_DATA_WIDTH_DEF = 32'd28;
    localparam int unsigned GAP_DEF           = 32'd8;

    // Channel index width; a single-channel build still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

    // Gap counter width: must hold GAP-1.
    function automatic int unsigned gap_width(input int unsigned gap);
        if (gap > 32'd2) begin
            return $clog2(gap);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/udma_adc_ts_rr_arb.sv
// Combinational rotating-priority arbiter.
// Grants the first requester at or after ptr_i+1, wrapping around.
// Ports:
//   req_i        request vector
//   ptr_i        index of the previously granted requester
//   gnt_onehot_o one-hot grant
//   gnt_idx_o    binary index of the grant
//   gnt_vld_o    at least one request present
module udma_adc_ts_rr_arb
    import udma_adc_ts_pkg::*;
#(
    parameter int unsigned N   = TS_NUM_CHS_DEF,
    localparam int unsigned IDW = id_width(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_onehot_o,
    output logic [IDW-1:0] gnt_idx_o,
    output logic           gnt_vld_o
);

    // Scan requesters starting one past the pointer; first hit wins.
    always_comb begin
        logic           found_s;
        logic [IDW-1:0] cand_s;
        int unsigned    pos_s;
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        found_s      = 1'b0;
        cand_s       = '0;
        pos_s        = 32'd0;
        for (int unsigned i = 0; i < N; i++) begin
            pos_s  = (32'(ptr_i) + 32'd1 + i) % N;
            cand_s = IDW'(pos_s);
            if (!found_s && req_i[cand_s]) begin
                found_s              = 1'b1;
                gnt_idx_o            = cand_s;
                gnt_onehot_o[cand_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        gnt_vld_o = found_s;
    end

endmodule

// File: rtl/udma_adc_ts_evt_sched.sv
// Timestamp event scheduler (ts_clk_i domain).
// Stamps per-channel events with a free-running counter, keeps one stamp
// per channel, round-robins pending channels onto ts_data_o and announces
// each stamp by toggling that channel's ts_valid_o bit. Each toggle is
// followed by GAP quiet cycles so downstream toggle synchronisers never
// see two toggles merge.
// Ports:
//   ts_clk_i, rst_ni  clock, async active-low reset
//   en_i              counter runs / new events accepted
//   cnt_clr_i         synchronous counter clear (wins over increment)
//   ch_mask_i         per-channel event enable
//   evt_i             per-channel single-cycle event pulses
//   ovf_clr_i         clears ovf_o (a same-cycle set wins)
//   ts_valid_o        per-channel toggle, one toggle per stamp
//   ts_data_o         stamp of the last issued event
//   ovf_o             sticky per-channel lost-event flag
//   busy_o            FSM active or anything pending
module udma_adc_ts_evt_sched
    import udma_adc_ts_pkg::*;
#(
    parameter int unsigned TS_NUM_CHS    = TS_NUM_CHS_DEF,
    parameter int unsigned TS_DATA_WIDTH = TS_DATA_WIDTH_DEF,
    parameter int unsigned GAP           = GAP_DEF
) (
    input  logic                     ts_clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     cnt_clr_i,
    input  logic [TS_NUM_CHS-1:0]    ch_mask_i,
    input  logic [TS_NUM_CHS-1:0]    evt_i,
    input  logic                     ovf_clr_i,
    output logic [TS_NUM_CHS-1:0]    ts_valid_o,
    output logic [TS_DATA_WIDTH-1:0] ts_data_o,
    output logic [TS_NUM_CHS-1:0]    ovf_o,
    output logic                     busy_o
);

    localparam int unsigned TS_ID_WIDTH = id_width(TS_NUM_CHS);
    localparam int unsigned GAP_W       = gap_width(GAP);

    logic [TS_DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [TS_DATA_WIDTH-1:0] stamp_q [TS_NUM_CHS];
    logic [TS_DATA_WIDTH-1:0] stamp_d [TS_NUM_CHS];
    logic [TS_NUM_CHS-1:0]    pending_q, pending_d;
    logic [TS_NUM_CHS-1:0]    ovf_q, ovf_d;
    sched_state_e             state_q, state_d;
    logic [TS_ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [TS_NUM_CHS-1:0]    gnt_oh_q, gnt_oh_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic [TS_NUM_CHS-1:0]    valid_q, valid_d;
    logic [TS_DATA_WIDTH-1:0] data_q, data_d;

    logic [TS_NUM_CHS-1:0]    accept_s;
    logic [TS_NUM_CHS-1:0]    issue_s;
    logic [TS_NUM_CHS-1:0]    arb_oh_s;
    logic [TS_ID_WIDTH-1:0]   arb_idx_s;
    logic                     arb_vld_s;

    udma_adc_ts_rr_arb #(
        .N (TS_NUM_CHS)
    ) i_rr_arb (
        .req_i        (pending_q),
        .ptr_i        (ptr_q),
        .gnt_onehot_o (arb_oh_s),
        .gnt_idx_o    (arb_idx_s),
        .gnt_vld_o    (arb_vld_s)
    );

    assign accept_s = evt_i & ch_mask_i & {TS_NUM_CHS{en_i}};

    // Channel being drained this cycle (its pending bit clears now).
    always_comb begin
        if (state_q == ISSUE) begin
            issue_s = gnt_oh_q;
        end else begin
            issue_s = '0;
        end
    end

    // Timestamp counter: clear wins over increment, frozen while disabled.
    always_comb begin
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(TS_DATA_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Per-channel capture: an event on the issuing channel starts a fresh stamp;
    // an event on a still-pending channel is lost and flagged.
    always_comb begin
        for (int unsigned k = 0; k < TS_NUM_CHS; k++) begin
            if (accept_s[k] && (!pending_q[k] || issue_s[k])) begin
                stamp_d[k] = cnt_q;
            end else begin
                stamp_d[k] = stamp_q[k];
            end

            if (accept_s[k]) begin
                pending_d[k] = 1'b1;
            end else if (issue_s[k]) begin
                pending_d[k] = 1'b0;
            end else begin
                pending_d[k] = pending_q[k];
            end

            if (accept_s[k] && pending_q[k] && !issue_s[k]) begin
                ovf_d[k] = 1'b1;
            end else if (ovf_clr_i) begin
                ovf_d[k] = 1'b0;
            end else begin
                ovf_d[k] = ovf_q[k];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge ts_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_vld_s) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:  state_d = LAUNCH;
            LAUNCH: state_d = HOLD;
            HOLD: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: grant capture, data load, toggle and pacing gap.
    always_comb begin
        ptr_d    = ptr_q;
        gnt_oh_d = gnt_oh_q;
        data_d   = data_q;
        valid_d  = valid_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (arb_vld_s) begin
                    ptr_d    = arb_idx_s;
                    gnt_oh_d = arb_oh_s;
                end else begin
                    ptr_d    = ptr_q;
                    gnt_oh_d = gnt_oh_q;
                end
            end
            ISSUE: begin
                data_d = stamp_q[ptr_q];
            end
            LAUNCH: begin
                valid_d = valid_q ^ gnt_oh_q;
                gap_d   = GAP_W'(GAP - 32'd1);
            end
            HOLD: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - {{(GAP_W-1){1'b0}}, 1'b1};
                end else begin
                    gap_d = gap_q;
                end
            end
            default: begin
                gap_d = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge ts_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            ptr_q     <= TS_ID_WIDTH'(TS_NUM_CHS - 32'd1);
            gnt_oh_q  <= '0;
            gap_q     <= '0;
            valid_q   <= '0;
            data_q    <= '0;
            for (int unsigned k = 0; k < TS_NUM_CHS; k++) begin
                stamp_q[k] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
            gnt_oh_q  <= gnt_oh_d;
            gap_q     <= gap_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            for (int unsigned k = 0; k < TS_NUM_CHS; k++) begin
                stamp_q[k] <= stamp_d[k];
            end
        end
    end

    assign ts_valid_o = valid_q;
    assign ts_data_o  = data_q;
    assign ovf_o      = ovf_q;
    assign busy_o     = (state_q != IDLE) | (|pending_q);

endmodule

// File: tb/tb_udma_adc_ts_evt_sched.sv
// Directed bench for udma_adc_ts_evt_sched (8 channels, 8-bit stamps, GAP=8).
module tb_udma_adc_ts_evt_sched;

    logic       ts_clk_i = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic       cnt_clr_i;
    logic [7:0] ch_mask_i;
    logic [7:0] evt_i;
    logic       ovf_clr_i;
    logic [7:0] ts_valid_o;
    logic [7:0] ts_data_o;
    logic [7:0] ovf_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;
    int idx;
    int cyc;

    udma_adc_ts_evt_sched #(
        .TS_NUM_CHS    (8),
        .TS_DATA_WIDTH (8),
        .GAP           (8)
    ) dut (
        .ts_clk_i   (ts_clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .cnt_clr_i  (cnt_clr_i),
        .ch_mask_i  (ch_mask_i),
        .evt_i      (evt_i),
        .ovf_clr_i  (ovf_clr_i),
        .ts_valid_o (ts_valid_o),
        .ts_data_o  (ts_data_o),
        .ovf_o      (ovf_o),
        .busy_o     (busy_o)
    );

    always #5 ts_clk_i = ~ts_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge ts_clk_i);
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        en_i      = 1'b1;
        cnt_clr_i = 1'b0;
        ch_mask_i = 8'hFF;
        evt_i     = 8'h00;
        ovf_clr_i = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    // Leaves the bench at a negedge where the counter equals v.
    task automatic set_cnt(input int v);
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        repeat (v) step();
    endtask

    // Waits (bounded) for the next ts_valid_o change; idx=-1 on timeout.
    task automatic wait_toggle(output int t_idx, output int t_cyc);
        logic [7:0] prev;
        logic [7:0] diff;
        prev  = ts_valid_o;
        t_idx = -1;
        t_cyc = 0;
        for (int c = 1; c <= 64; c++) begin
            step();
            diff = ts_valid_o ^ prev;
            if (diff != 8'h00) begin
                t_cyc = c;
                for (int b = 0; b < 8; b++) begin
                    if (diff[b]) t_idx = b;
                end
                break;
            end
        end
    endtask

    initial begin
        rst_ni    = 1'b0;
        en_i      = 1'b1;
        cnt_clr_i = 1'b0;
        ch_mask_i = 8'hFF;
        evt_i     = 8'h00;
        ovf_clr_i = 1'b0;
        step();
        check("rst_valid", 32'(ts_valid_o), 32'h0);
        check("rst_data",  32'(ts_data_o),  32'h0);
        check("rst_ovf",   32'(ovf_o),      32'h0);
        check("rst_busy",  32'(busy_o),     32'h0);

        // 1: single event latency and busy window
        do_reset();
        set_cnt(100);
        evt_i = 8'h04;
        step();                                   // E0
        evt_i = 8'h00;
        check("t1_busy_e0", 32'(busy_o), 32'h1);
        step();                                   // E1
        check("t1_data_e1", 32'(ts_data_o), 32'h0);
        step();                                   // E2
        check("t1_data_e2",  32'(ts_data_o),  32'd100);
        check("t1_valid_e2", 32'(ts_valid_o), 32'h00);
        step();                                   // E3
        check("t1_valid_e3", 32'(ts_valid_o), 32'h04);
        repeat (7) step();
        check("t1_busy_hold", 32'(busy_o), 32'h1);
        step();
        check("t1_busy_done", 32'(busy_o), 32'h0);

        // 2: simultaneous events, round robin from reset pointer
        do_reset();
        set_cnt(40);
        evt_i = 8'h21;
        step();
        evt_i = 8'h00;
        wait_toggle(idx, cyc);
        check("t2_first_idx", 32'(idx), 32'd0);
        check("t2_first_cyc", 32'(cyc), 32'd3);
        check("t2_first_dat", 32'(ts_data_o), 32'd40);
        wait_toggle(idx, cyc);
        check("t2_second_idx", 32'(idx), 32'd5);
        check("t2_second_cyc", 32'(cyc), 32'd11);
        check("t2_second_dat", 32'(ts_data_o), 32'd40);
        check("t2_valid", 32'(ts_valid_o), 32'h21);

        // 3: lost event on busy channel sets ovf, first stamp wins
        do_reset();
        set_cnt(9);
        evt_i = 8'h02; step();                    // ch1 @9
        evt_i = 8'h08; step();                    // ch3 @10
        evt_i = 8'h00; step();
        evt_i = 8'h08; step();                    // ch3 @12, ch1 toggles here
        evt_i = 8'h00;
        check("t3_ch1_valid", 32'(ts_valid_o), 32'h02);
        check("t3_ch1_data",  32'(ts_data_o),  32'd9);
        check("t3_ovf_set",   32'(ovf_o),      32'h08);
        wait_toggle(idx, cyc);
        check("t3_ch3_idx",  32'(idx), 32'd3);
        check("t3_ch3_cyc",  32'(cyc), 32'd11);
        check("t3_ch3_data", 32'(ts_data_o), 32'd10);
        check("t3_ovf_kept", 32'(ovf_o), 32'h08);
        ovf_clr_i = 1'b1; step(); ovf_clr_i = 1'b0;
        check("t3_ovf_clr", 32'(ovf_o), 32'h00);

        // 4a: re-event in the issue cycle is a fresh stamp, not an overflow
        do_reset();
        set_cnt(60);
        evt_i = 8'h10; step();
        evt_i = 8'h00; step();
        evt_i = 8'h10; step();                    // issue cycle, cnt 62
        evt_i = 8'h00;
        check("t4a_ovf",  32'(ovf_o), 32'h00);
        check("t4a_data", 32'(ts_data_o), 32'd60);
        step();
        check("t4a_valid", 32'(ts_valid_o), 32'h10);
        wait_toggle(idx, cyc);
        check("t4a_idx2",  32'(idx), 32'd4);
        check("t4a_data2", 32'(ts_data_o), 32'd62);

        // 4b: continuous events on ch1 and ch6 alternate
        do_reset();
        set_cnt(20);
        evt_i = 8'h42;
        wait_toggle(idx, cyc);
        check("t4b_idx0", 32'(idx), 32'd1);
        check("t4b_dat0", 32'(ts_data_o), 32'd20);
        wait_toggle(idx, cyc);
        check("t4b_idx1", 32'(idx), 32'd6);
        check("t4b_cyc1", 32'(cyc), 32'd11);
        check("t4b_dat1", 32'(ts_data_o), 32'd20);
        wait_toggle(idx, cyc);
        check("t4b_idx2", 32'(idx), 32'd1);
        check("t4b_dat2", 32'(ts_data_o), 32'd22);
        wait_toggle(idx, cyc);
        check("t4b_idx3", 32'(idx), 32'd6);
        check("t4b_dat3", 32'(ts_data_o), 32'd33);
        evt_i = 8'h00;

        // 5: counter wrap, clear, enable and mask gating
        do_reset();
        set_cnt(255);
        evt_i = 8'h01; step();                    // stamp 255
        evt_i = 8'h02; step();                    // stamp 0 after wrap
        evt_i = 8'h00;
        wait_toggle(idx, cyc);
        check("t5_wrap_idx0", 32'(idx), 32'd0);
        check("t5_wrap_dat0", 32'(ts_data_o), 32'd255);
        wait_toggle(idx, cyc);
        check("t5_wrap_idx1", 32'(idx), 32'd1);
        check("t5_wrap_dat1", 32'(ts_data_o), 32'd0);
        set_cnt(50);
        cnt_clr_i = 1'b1; evt_i = 8'h04; step();  // stamp 50, clear
        cnt_clr_i = 1'b0; evt_i = 8'h08; step();  // stamp 0
        evt_i = 8'h00;
        wait_toggle(idx, cyc);
        check("t5_clr_idx0", 32'(idx), 32'd2);
        check("t5_clr_dat0", 32'(ts_data_o), 32'd50);
        wait_toggle(idx, cyc);
        check("t5_clr_idx1", 32'(idx), 32'd3);
        check("t5_clr_dat1", 32'(ts_data_o), 32'd0);
        repeat (12) step();
        set_cnt(30);
        en_i = 1'b0; evt_i = 8'h20; step();
        evt_i = 8'h00; step(); step();
        check("t5_en_ignored", 32'(busy_o), 32'h0);
        en_i = 1'b1; evt_i = 8'h20; step();
        evt_i = 8'h00;
        wait_toggle(idx, cyc);
        check("t5_en_idx",  32'(idx), 32'd5);
        check("t5_en_data", 32'(ts_data_o), 32'd30);
        repeat (12) step();
        ch_mask_i = 8'hFE; evt_i = 8'h01; step();
        evt_i = 8'h00; ch_mask_i = 8'hFF; step();
        check("t5_masked", 32'(busy_o), 32'h0);

        // 6: reset during HOLD with channels pending
        do_reset();
        set_cnt(5);
        evt_i = 8'h07; step();
        evt_i = 8'h00;
        wait_toggle(idx, cyc);
        check("t6_first_idx", 32'(idx), 32'd0);
        step(); step();
        check("t6_busy_hold", 32'(busy_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_valid", 32'(ts_valid_o), 32'h0);
        check("t6_rst_data",  32'(ts_data_o),  32'h0);
        check("t6_rst_ovf",   32'(ovf_o),      32'h0);
        check("t6_rst_busy",  32'(busy_o),     32'h0);
        step();
        rst_ni = 1'b1;
        repeat (30) step();
        check("t6_post_valid", 32'(ts_valid_o), 32'h0);
        check("t6_post_busy",  32'(busy_o),     32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
